// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Purpose  : RV32M/RV64M companion for the EX stage. Decodes M-extension ops
//            and runs them on an iterative shift-add multiplier / restoring
//            divider. The pipeline is held through a stall/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      ALUOp,
  input  logic            funct7_0,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            is_m,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

  localparam logic [2:0] C_IDLE = 3'd0;
  localparam logic [2:0] C_MUL  = 3'd1;
  localparam logic [2:0] C_DIV  = 3'd2;
  localparam logic [2:0] C_FIX  = 3'd3;
  localparam logic [2:0] C_DONE = 3'd4;

  localparam logic [XLEN-1:0] C_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // State and datapath registers. acc_q holds the running product, or
  // {remainder, quotient} while dividing; the extra top bit catches carries.
  logic [2:0]      state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [2*XLEN:0] acc_q,    acc_d;
  logic [XLEN-1:0] mcand_q,  mcand_d;   // multiplicand magnitude or divisor magnitude
  logic [2:0]      f3_q,     f3_d;
  logic            neg_q,    neg_d;     // signs of operands differ (signed ops only)
  logic            nega_q,   nega_d;    // dividend was negative (signed ops only)
  logic            spec_q,   spec_d;    // divide-by-zero or signed overflow
  logic [XLEN-1:0] spval_q,  spval_d;   // architected result of the special case
  logic [XLEN-1:0] result_q, result_d;

  // Decode and accept-time operand conditioning.
  logic            w_accept;
  logic            w_a_signed, w_b_signed, w_neg_a, w_neg_b;
  logic [XLEN-1:0] w_amag, w_bmag;
  logic            w_div0, w_ovf;
  logic [XLEN-1:0] w_spval;

  // Iteration and fix-up datapath.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN:0]   w_mul_nxt;
  logic [2*XLEN:0]   w_sh;
  logic [XLEN+1:0]   w_trial;
  logic [2*XLEN:0]   w_div_nxt;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s, w_rem_s;
  logic [XLEN-1:0]   w_fix_res;

  assign is_m   = (ALUOp == 3'b010) && funct7_0;
  assign busy   = (state_q != C_IDLE) && (state_q != C_DONE);
  assign done   = (state_q == C_DONE);
  assign stall  = busy | (start & is_m & (state_q == C_IDLE));
  assign result = result_q;

  // Operand decode: signedness per funct3, magnitudes and special-case detection.
  always_comb begin
    w_accept   = start & is_m & (state_q == C_IDLE) & ~flush;
    w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    w_neg_a    = w_a_signed & op_a[XLEN-1];
    w_neg_b    = w_b_signed & op_b[XLEN-1];
    w_amag     = w_neg_a ? (-op_a) : op_a;
    w_bmag     = w_neg_b ? (-op_b) : op_b;
    w_div0     = funct3[2] & (op_b == '0);
    w_ovf      = funct3[2] & ~funct3[0] & (op_a == C_MOST_NEG) & (&op_b);
    if (w_div0) begin
      w_spval = funct3[1] ? op_a : '1;
    end else begin
      w_spval = funct3[1] ? '0 : op_a;
    end
  end

  // One multiply step, one restoring-divide step, and the final sign fix-up.
  always_comb begin
    w_mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
    if (acc_q[0]) begin
      w_mul_nxt = {1'b0, w_mul_sum, acc_q[XLEN-1:1]};
    end else begin
      w_mul_nxt = {1'b0, acc_q[2*XLEN:1]};
    end

    w_sh    = {acc_q[2*XLEN-1:0], 1'b0};
    w_trial = {1'b0, w_sh[2*XLEN:XLEN]} - {2'b00, mcand_q};
    if (!w_trial[XLEN+1]) begin
      w_div_nxt = {w_trial[XLEN:0], w_sh[XLEN-1:1], 1'b1};
    end else begin
      w_div_nxt = w_sh;
    end

    w_prod_s = neg_q  ? (-acc_q[2*XLEN-1:0])    : acc_q[2*XLEN-1:0];
    w_quo_s  = neg_q  ? (-acc_q[XLEN-1:0])      : acc_q[XLEN-1:0];
    w_rem_s  = nega_q ? (-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:                 w_fix_res = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quo_s;
      default:                w_fix_res = w_rem_s;
    endcase
    if (spec_q) begin
      w_fix_res = spval_q;
    end
  end

  // Next-state logic for the sequencer and all datapath registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    nega_d   = nega_q;
    spec_d   = spec_q;
    spval_d  = spval_q;
    result_d = result_q;
    case (state_q)
      C_IDLE: begin
        if (w_accept) begin
          f3_d    = funct3;
          neg_d   = w_neg_a ^ w_neg_b;
          nega_d  = w_neg_a;
          spec_d  = w_div0 | w_ovf;
          spval_d = w_spval;
          cnt_d   = '0;
          if (FAST_SPECIAL && (w_div0 || w_ovf)) begin
            state_d  = C_DONE;
            result_d = w_spval;
          end else if (funct3[2]) begin
            state_d = C_DIV;
            mcand_d = w_bmag;
            acc_d   = {{(XLEN+1){1'b0}}, w_amag};
          end else begin
            state_d = C_MUL;
            mcand_d = w_amag;
            acc_d   = {{(XLEN+1){1'b0}}, w_bmag};
          end
        end
      end
      C_MUL: begin
        acc_d = w_mul_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) state_d = C_FIX;
      end
      C_DIV: begin
        acc_d = w_div_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) state_d = C_FIX;
      end
      C_FIX: begin
        result_d = w_fix_res;
        state_d  = C_DONE;
      end
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
    // A pipeline kill abandons the op without touching the visible result.
    if (flush) begin
      state_d  = C_IDLE;
      result_d = result_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= C_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
      spec_q   <= 1'b0;
      spval_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      nega_q   <= nega_d;
      spec_q   <= spec_d;
      spval_q  <= spval_d;
      result_q <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Next-generation ALU control companion for the EX stage.
- Decodes the RV32M/RV64M subset: R-type with funct7[0]=1, routed on ALUOp=3'b010.
- Executes the decoded op on an iterative, XLEN-parametrised shift-add multiplier / restoring divider.
- Holds the pipeline through a stall/done handshake while the base ALU path handles all other ops.

Parameters:
XLEN, 32, operand/result width (32 or 64)
FAST_SPECIAL, 1, 1 = divide-by-zero and signed overflow complete in 1 cycle; 0 = they take the full iterative latency

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  EX-stage instruction valid
ALUOp  in  3  main-control ALU op (3'b010 = R-type)
funct7_0  in  1  instruction bit 25 (M-extension select)
funct3  in  3  op select within M extension
op_a  in  XLEN  rs1 value (multiplicand/dividend)
op_b  in  XLEN  rs2 value (multiplier/divisor)
flush  in  1  pipeline kill; aborts an in-flight op
is_m  out  1  combinational: ALUOp==3'b010 && funct7_0
stall  out  1  hold IF/ID/EX: busy | (start & is_m & state==IDLE)
busy  out  1  registered: state != IDLE and state != DONE
done  out  1  one-cycle pulse, result valid
result  out  XLEN  registered result, held until the next accept

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0; done=0; result=0; all internal registers cleared. Reset mid-operation discards the op with no done pulse.
- funct3 map:
  - 000 MUL: low XLEN bits
  - 001 MULH: signed×signed, high
  - 010 MULHSU: signed×unsigned, high
  - 011 MULHU: high
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- Accept: start & is_m & state==IDLE & ~flush at a rising edge.
  - Latch op, sign flags, |op_a|, |op_b| (abs only for signed operands).
  - Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
  - start while busy or while in DONE is ignored. The pipeline must keep it asserted because stall is high.
- MUL: XLEN cycles. Each cycle: if multiplier LSB is set, add multiplicand into the upper half of a 2·XLEN accumulator; then shift right 1. Then FIX.
- DIV: XLEN cycles of restoring division on magnitudes. Each cycle: shift remainder:quotient left 1; trial-subtract divisor; keep if non-negative and set quotient bit. Then FIX.
- FIX (1 cycle): negate the product if signs differ (signed ops). Quotient negated if sign(a)≠sign(b). Remainder takes the sign of the dividend. Select low/high half or quotient/remainder into result. Go to DONE.
- DONE (1 cycle): done=1, busy=0, stall=0. Next state IDLE. If start & is_m is present in DONE it is not accepted until IDLE.
- Latency: accept edge = edge 0; done high in the cycle after edge XLEN+1 (XLEN+2 cycles; 34 for XLEN=32). stall is high from the accept cycle through the FIX cycle.
- Special cases (decided at accept, FAST_SPECIAL=1: go straight to DONE, done in cycle 2):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (op_a = most negative, op_b = −1): DIV = op_a; REM = 0.
  - With FAST_SPECIAL=0 these values are forced in FIX instead.
- flush: in any state, next edge → IDLE; done suppressed; result unchanged. flush on the accept edge prevents acceptance.
- Multiply by zero takes full latency (no early-out).
- All arithmetic is internal 2·XLEN+1 bits. No width truncation before FIX.

Test Plan:
- MUL 7 × 0xFFFFFFFD (XLEN=32) → result 0xFFFFFFEB; done pulses exactly 34 cycles after the accept edge; stall high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, done in cycle 2. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- flush asserted at cycle 10 of a DIV → idle next cycle, no done, result retains the previous value. Then a new MUL is accepted normally.
- rst_n low at cycle 5 of a MUL → busy/done/result 0 immediately. ALUOp=3'b000 with start → is_m=0, stall=0, no accept.
